// File: rtl/mul_arbiter_pkg.sv
// Shared types and sizing for the two-requester iterative multiplier.
// Signed operation is selected by MUL_ARBITER_SIGNED_EN in the files that import this package.
package mul_arbiter_pkg;

    localparam int OP_W  = 32;
    localparam int RES_W = 64;
    localparam int ITER  = 32;
    localparam int CNT_W = $clog2(ITER);

    typedef logic req_id_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } state_t;

    // Round-robin pick: a lone request wins, a tie goes to whoever was not granted last.
    function automatic req_id_t arb_pick(input logic [1:0] req, input req_id_t last);
        if (req == 2'b11) begin
            return ~last;
        end else if (req[1]) begin
            return 1'b1;
        end else begin
            return 1'b0;
        end
    endfunction

endpackage

// File: rtl/mul_core.sv
// Shift-add multiplier datapath: one multiplier bit per step, LSB first, 32-bit ripple adder.
// Sign handling lives in the parent; this core always multiplies magnitudes.
module mul_core
    import mul_arbiter_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [OP_W-1:0]  i_mcand,
    input  logic [OP_W-1:0]  i_mplier,
    output logic [RES_W-1:0] o_prod,
    output logic             o_last
);

    logic [OP_W-1:0]  r_mcand;
    logic [OP_W-1:0]  r_hi;
    logic [OP_W-1:0]  r_lo;
    logic [CNT_W-1:0] r_cnt;

    logic [OP_W-1:0]  w_addend;
    logic [OP_W-1:0]  w_sum;
    logic             w_cout;

    always_comb begin
        logic v_c;
        w_addend = r_lo[0] ? r_mcand : '0;
        w_sum    = '0;
        v_c      = 1'b0;
        for (int i = 0; i < OP_W; i++) begin
            w_sum[i] = r_hi[i] ^ w_addend[i] ^ v_c;
            v_c      = (r_hi[i] & w_addend[i]) | (v_c & (r_hi[i] ^ w_addend[i]));
        end
        w_cout = v_c;
    end

    // Down-counter loaded with ITER-1; the step taken at zero is the final one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_mcand <= i_mcand;
            r_hi    <= '0;
            r_lo    <= i_mplier;
            r_cnt   <= CNT_W'(ITER - 1);
        end else if (i_step) begin
            r_hi <= {w_cout, w_sum[OP_W-1:1]};
            r_lo <= {w_sum[0], r_lo[OP_W-1:1]};
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_prod = {r_hi, r_lo};
    assign o_last = (r_cnt == '0);

endmodule

// File: rtl/mul_arbiter.sv
// Two-requester round-robin front end sharing one iterative 32x32 multiplier.
// Define MUL_ARBITER_SIGNED_EN for two's-complement operands; default build is unsigned.
//
// state | meaning
// IDLE  | waiting for a request; grant chosen on the accepting edge
// LOAD  | ack pulse to the granted requester; its operands captured at the end
// RUN   | 32 shift-add iterations in mul_core
// FIX   | optional sign correction; result registered at the end
// DONE  | valid strobe, then unconditionally back to IDLE
module mul_arbiter
    import mul_arbiter_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [OP_W-1:0]  opa0,
    input  logic [OP_W-1:0]  opb0,
    input  logic [OP_W-1:0]  opa1,
    input  logic [OP_W-1:0]  opb1,
    output logic [1:0]       ack,
    output logic [RES_W-1:0] result,
    output logic             valid,
    output logic             valid_id,
    output logic             busy
);

    state_t           r_state;
    state_t           w_state_nxt;
    req_id_t          r_grant;
    req_id_t          r_last;
    logic [RES_W-1:0] r_result;
    req_id_t          r_valid_id;

    logic [OP_W-1:0]  w_opa;
    logic [OP_W-1:0]  w_opb;
    logic [OP_W-1:0]  w_mcand;
    logic [OP_W-1:0]  w_mplier;
    logic [RES_W-1:0] w_prod;
    logic [RES_W-1:0] w_fixed;
    logic             w_last;
    logic             w_load;
    logic             w_step;
    req_id_t          w_pick;

    assign w_opa  = r_grant ? opa1 : opa0;
    assign w_opb  = r_grant ? opb1 : opb0;
    assign w_pick = arb_pick(req, r_last);

`ifdef MUL_ARBITER_SIGNED_EN
    logic r_sign;

    assign w_mcand  = w_opa[OP_W-1] ? -w_opa : w_opa;
    assign w_mplier = w_opb[OP_W-1] ? -w_opb : w_opb;
    assign w_fixed  = r_sign ? -w_prod : w_prod;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sign <= 1'b0;
        end else if (r_state == ST_LOAD) begin
            r_sign <= w_opa[OP_W-1] ^ w_opb[OP_W-1];
        end
    end
`else
    assign w_mcand  = w_opa;
    assign w_mplier = w_opb;
    assign w_fixed  = w_prod;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        ack         = 2'b00;
        unique case (r_state)
            ST_IDLE: if (|req) w_state_nxt = ST_LOAD;
            ST_LOAD: begin
                w_load      = 1'b1;
                ack         = r_grant ? 2'b10 : 2'b01;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (w_last) w_state_nxt = ST_FIX;
            end
            ST_FIX:  w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_grant    <= 1'b0;
            r_last     <= 1'b1;
            r_result   <= '0;
            r_valid_id <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && |req) begin
                r_grant <= w_pick;
                r_last  <= w_pick;
            end
            if (r_state == ST_FIX) begin
                r_result   <= w_fixed;
                r_valid_id <= r_grant;
            end
        end
    end

    mul_core u_core (
        .clock    (clock),
        .reset    (reset),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_mcand  (w_mcand),
        .i_mplier (w_mplier),
        .o_prod   (w_prod),
        .o_last   (w_last)
    );

    assign result   = r_result;
    assign valid_id = r_valid_id;
    assign valid    = (r_state == ST_DONE);
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed and randomized bench for mul_arbiter against a plain-arithmetic reference.
// Honours MUL_ARBITER_SIGNED_EN so the same bench covers both builds.
module tb_mul_arbiter;

    logic        clock;
    logic        reset;
    logic [1:0]  req;
    logic [31:0] opa0, opb0, opa1, opb1;
    logic [1:0]  ack;
    logic [63:0] result;
    logic        valid;
    logic        valid_id;
    logic        busy;

    int vectors    = 0;
    int miscompares = 0;
    logic m_last;

    mul_arbiter dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .opa0     (opa0),
        .opb0     (opb0),
        .opa1     (opa1),
        .opb1     (opb1),
        .ack      (ack),
        .result   (result),
        .valid    (valid),
        .valid_id (valid_id),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_ARBITER_SIGNED_EN
        logic signed [63:0] sa, sb;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        return sa * sb;
`else
        return {32'b0, a} * {32'b0, b};
`endif
    endfunction

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ack"},      64'(ack),      64'd0);
        check({tag, "_valid"},    64'(valid),    64'd0);
        check({tag, "_valid_id"}, 64'(valid_id), 64'd0);
        check({tag, "_busy"},     64'(busy),     64'd0);
        check({tag, "_result"},   result,        64'd0);
    endtask

    // Caller sits just after an edge; reset asserts asynchronously right here.
    task automatic apply_reset(input string tag);
        reset = 1'b1;
        req   = 2'b00;
        #1;
        check_quiet(tag);
        tick();
        reset  = 1'b0;
        m_last = 1'b1;
        tick();
    endtask

    task automatic randomize_ops();
        opa0 = pick_op();
        opb0 = pick_op();
        opa1 = pick_op();
        opb1 = pick_op();
    endtask

    // One whole transaction starting with the DUT idle; ends in the IDLE cycle after DONE.
    task automatic do_op(input logic [1:0] rq, input bit drop, input bit toggle);
        logic        exp_id;
        logic [63:0] exp_p;
        int          n, acks, gid, oth;
        req = rq;
        if (rq == 2'b01)      exp_id = 1'b0;
        else if (rq == 2'b10) exp_id = 1'b1;
        else                  exp_id = ~m_last;
        m_last = exp_id;
        gid = exp_id ? 1 : 0;
        oth = exp_id ? 0 : 1;
        exp_p = exp_id ? model(opa1, opb1) : model(opa0, opb0);
        tick();
        check("ack_grant", 64'(ack), exp_id ? 64'd2 : 64'd1);
        acks = (ack != 2'b00) ? 1 : 0;
        if (drop) req[gid] = 1'b0;
        n = 0;
        while (valid !== 1'b1 && n < 60) begin
            if (toggle && n < 30) req[oth] = 1'($urandom_range(1, 0));
            tick();
            n++;
            if (ack !== 2'b00) acks++;
        end
        if (toggle) req[oth] = 1'b1;
        check("latency",    64'(n),        64'd34);
        check("ack_pulses", 64'(acks),     64'd1);
        check("result",     result,        exp_p);
        check("valid_id",   64'(valid_id), 64'(exp_id));
        check("busy_done",  64'(busy),     64'd1);
        tick();
        check("idle_gap", {61'd0, ack, valid, busy}, 64'd0);
    endtask

    initial begin
        int  n, vcount;
        reset = 1'b1;
        req   = 2'b00;
        opa0  = '0; opb0 = '0; opa1 = '0; opb1 = '0;
        m_last = 1'b1;
        tick();
        tick();
        apply_reset("por");

        opa0 = 32'd6; opb0 = 32'd7;
        do_op(2'b01, 1'b1, 1'b0);
        opa1 = 32'hFFFF_FFFF; opb1 = 32'hFFFF_FFFF;
        do_op(2'b10, 1'b1, 1'b0);
`ifdef MUL_ARBITER_SIGNED_EN
        opa0 = 32'hFFFF_FFFD; opb0 = 32'd7;
        do_op(2'b01, 1'b1, 1'b0);
        opa0 = 32'h8000_0000; opb0 = 32'h8000_0000;
        do_op(2'b01, 1'b1, 1'b0);
`endif

        // Both requesters held continuously from reset: grants must alternate.
        req = 2'b00;
        apply_reset("rr_rst");
        randomize_ops();
        for (int k = 0; k < 3; k++) do_op(2'b11, 1'b0, 1'b0);
        req = 2'b00;

        // Requester 1 chatters during the run, then holds and is served next.
        randomize_ops();
        do_op(2'b01, 1'b1, 1'b1);
        do_op(2'b10, 1'b1, 1'b0);

        for (int k = 0; k < 8; k++) begin
            randomize_ops();
            do_op(2'($urandom_range(3, 1)), 1'($urandom_range(1, 0)), 1'b0);
        end
        req = 2'b00;

        // Abort in RUN cycle 10, then confirm no stray completion.
        randomize_ops();
        req = 2'b01;
        tick();
        check("abort_ack", 64'(ack), 64'd1);
        for (int k = 0; k < 10; k++) tick();
        check("abort_busy", 64'(busy), 64'd1);
        apply_reset("abort");
        vcount = 0;
        for (n = 0; n < 40; n++) begin
            tick();
            if (valid === 1'b1) vcount++;
        end
        check("abort_no_valid", 64'(vcount), 64'd0);
        randomize_ops();
        do_op(2'b01, 1'b1, 1'b0);
        do_op(2'b11, 1'b0, 1'b0);
        req = 2'b00;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: req  input  2  per-requester multiply request; bit n = requester n; level-held until ack.
REQ-004 SHALL have ports: opa0, opb0, opa1, opb1  input  32 each  operands of requesters 0/1; stable while the matching req bit is high.
REQ-005 SHALL have port: ack  output  2  one-cycle pulse on the granted bit; operands captured on the edge ending that cycle.
REQ-006 SHALL have port: result  output  64  product; holds its value until the next completion.
REQ-007 SHALL have port: valid  output  1  one-cycle completion strobe.
REQ-008 SHALL have port: valid_id  output  1  requester owning the current result.
REQ-009 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-010 SHALL implement states IDLE, LOAD, RUN, FIX, DONE; DONE returns to IDLE unconditionally.
REQ-011 In IDLE with any req bit high, SHALL pick a grant and enter LOAD on the next edge; with no req, stay in IDLE.
REQ-012 Arbitration SHALL be round-robin: a single request wins; on both, the requester not granted last wins; last-grant resets to 1 so requester 0 wins the first tie.
REQ-013 ack[g] SHALL be high exactly during the LOAD cycle; operands of g latched at the end of LOAD; ack otherwise 0.
REQ-014 RUN SHALL last exactly 32 cycles of shift-add iteration (one multiplier bit per cycle, LSB first) via mul_core, then go to FIX.
REQ-015 FIX (one cycle) SHALL apply sign correction per REQ-022/023, then go to DONE.
REQ-016 valid SHALL be high exactly during DONE, i.e. 34 edges after the IDLE edge that accepted the request; result and valid_id update on entry to DONE.
REQ-017 req bits SHALL be ignored while busy; a request arriving or held during an operation is served from IDLE afterwards.
REQ-018 Back-to-back: with both req held continuously, grants SHALL alternate 0,1,0,1; one IDLE cycle separates DONE from the next LOAD.
REQ-019 Product width SHALL be full 64 bits; no truncation or overflow flag.

Reset
REQ-020 On reset assertion, SHALL immediately go to IDLE: ack=0, valid=0, valid_id=0, busy=0, result=0, last-grant=1, iteration counter=0.
REQ-021 Reset mid-operation SHALL abort the operation with no valid pulse; its requester must re-request.

Configuration
REQ-022 With MUL_ARBITER_SIGNED_EN defined, operands SHALL be two's-complement: LOAD converts to magnitudes, saves sign=opa[31]^opb[31], FIX negates the 64-bit product when sign=1.
REQ-023 Without MUL_ARBITER_SIGNED_EN, operands SHALL be unsigned and FIX SHALL pass the product unchanged; cycle timing identical in both builds.

Structure
REQ-024 Package mul_arbiter_pkg SHALL hold the state enum, OP_W=32, RES_W=64, ITER=32 and the requester-id type.
REQ-025 The iterative datapath (accumulator, shift register, 32-bit ripple adder, counter) SHALL be the sub-module mul_core; mul_arbiter holds FSM, arbitration and sign handling.

Verification
REQ-026 Unsigned: req=01, opa0=6, opb0=7 -> ack=01 one cycle, valid 34 edges after acceptance, result=42, valid_id=0.
REQ-027 Unsigned: opa1=opb1=32'hFFFFFFFF, req=10 -> result=64'hFFFFFFFE00000001, valid_id=1.
REQ-028 Signed build: opa0=-3, opb0=7 -> result=64'hFFFFFFFFFFFFFFEB; opa0=opb0=32'h80000000 -> result=64'h4000000000000000.
REQ-029 Both req held for three operations from reset -> valid_id sequence 0,1,0; exactly one ack pulse per grant.
REQ-030 Reset asserted in RUN cycle 10 -> outputs zero immediately, no valid; a fresh req=01 afterwards completes with correct result in 34 edges.
REQ-031 req toggled during RUN -> no ack until DONE->IDLE; held request then granted normally.
